// File: rtl/noc_packet_sink_checker_if.sv
// noc_packet_sink_checker_if: valid/ready flit link from a router sender port into the packet sink
interface noc_packet_sink_checker_if #(parameter int DATA_W = 32);
   logic              receive_valid;
   logic              receive_ready;
   logic [DATA_W-1:0] receive_flit;
   logic              receive_is_header;
   logic              receive_is_tail;
   modport master (output receive_valid, receive_flit, receive_is_header, receive_is_tail, input receive_ready);
   modport slave (input receive_valid, receive_flit, receive_is_header, receive_is_tail, output receive_ready);
endinterface

// File: rtl/noc_packet_sink_checker.sv
// noc_packet_sink_checker: terminal NoC receiver that reassembles packets and checks header, length and payload.
// Optional NOC_SINK_BACKPRESSURE_EN drives receive_ready from a free-running LFSR.
module noc_packet_sink_checker #(
   parameter int DATA_W        = 32,
   parameter int X_ID          = 0,
   parameter int Y_ID          = 0,
   parameter int CHECK_PAYLOAD = 1
) (
   input  logic                      noc_clk,
   input  logic                      noc_rst_n,
   noc_packet_sink_checker_if.slave  rx,
   output logic [7:0]                pkt_count,
   output logic [15:0]               flit_count,
   output logic [7:0]                err_count,
   output logic [4:0]                err_flags,
   output logic [7:0]                last_src,
   output logic                      busy
);
   typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;
   localparam logic [3:0] XI = 4'(X_ID);
   localparam logic [3:0] YI = 4'(Y_ID);
   state_t            state_q, state_d;
   logic [7:0]        k_q, k_d, len_q, len_d, seq_q, seq_d, src_q, src_d;
   logic [7:0]        pkt_count_q, pkt_count_d, err_count_q, err_count_d, last_src_q, last_src_d;
   logic [15:0]       flit_count_q, flit_count_d;
   logic [4:0]        err_flags_q, err_flags_d;
   logic              dest_err_q, dest_err_d, pay_err_q, pay_err_d;
   logic              acc, hdr_dest_ok, pay_ok, len_ok;
   logic [1:0]        err_inc;
   logic [8:0]        err_sum;
   logic [DATA_W-1:0] f;
`ifdef NOC_SINK_BACKPRESSURE_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        started_q, started_d;
   // Fibonacci LFSR (taps 16,14,13,11) paces ready; ready stays low for the first cycle out of reset
   always_comb begin
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      started_d = 1'b1;
   end
   // Backpressure generator registers
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         lfsr_q    <= 16'hACE1;
         started_q <= 1'b0;
      end else begin
         lfsr_q    <= lfsr_d;
         started_q <= started_d;
      end
   end
   assign rx.receive_ready = started_q & lfsr_q[0];
`else
   assign rx.receive_ready = 1'b1;
`endif
   // Packet FSM: a header always closes any open packet (as missing-tail) before being decoded
   always_comb begin
      acc          = rx.receive_valid & rx.receive_ready;
      f            = rx.receive_flit;
      hdr_dest_ok  = (f[7:4] == XI) && (f[3:0] == YI);
      pay_ok       = (CHECK_PAYLOAD == 0) || (f[15:0] == {seq_q, k_q});
      len_ok       = k_q == len_q;
      state_d      = state_q;
      k_d          = k_q;
      len_d        = len_q;
      seq_d        = seq_q;
      src_d        = src_q;
      dest_err_d   = dest_err_q;
      pay_err_d    = pay_err_q;
      pkt_count_d  = pkt_count_q;
      flit_count_d = flit_count_q;
      err_flags_d  = err_flags_q;
      last_src_d   = last_src_q;
      err_inc      = 2'd0;
      if (acc) begin
         flit_count_d = flit_count_q + 16'd1;
         if (rx.receive_is_header) begin
            if (state_q != IDLE) begin
               err_flags_d[1] = 1'b1;
               if (dest_err_q) err_flags_d[2] = 1'b1;
               err_inc = err_inc + 2'd1;
            end
            if (rx.receive_is_tail) begin
               state_d = IDLE;
               if (hdr_dest_ok && f[23:16] == 8'd0) begin
                  pkt_count_d = pkt_count_q + 8'd1;
                  last_src_d  = f[15:8];
               end else begin
                  if (!hdr_dest_ok) err_flags_d[2] = 1'b1;
                  if (f[23:16] != 8'd0) err_flags_d[3] = 1'b1;
                  err_inc = err_inc + 2'd1;
               end
            end else begin
               state_d    = BODY;
               src_d      = f[15:8];
               len_d      = f[23:16];
               seq_d      = f[31:24];
               k_d        = 8'd1;
               dest_err_d = !hdr_dest_ok;
               pay_err_d  = 1'b0;
            end
         end else if (state_q == IDLE) begin
            err_flags_d[0] = 1'b1;
            err_inc        = 2'd1;
         end else if (state_q == DRAIN) begin
            if (rx.receive_is_tail) begin
               state_d = IDLE;
               if (dest_err_q) err_flags_d[2] = 1'b1;
               err_inc = 2'd1;
            end
         end else if (!rx.receive_is_tail) begin
            if (len_ok) begin
               err_flags_d[3] = 1'b1;
               state_d        = DRAIN;
            end else begin
               if (!pay_ok) begin
                  pay_err_d      = 1'b1;
                  err_flags_d[4] = 1'b1;
               end
               k_d = k_q + 8'd1;
            end
         end else begin
            state_d = IDLE;
            if (!pay_ok) err_flags_d[4] = 1'b1;
            if (!len_ok) err_flags_d[3] = 1'b1;
            if (dest_err_q) err_flags_d[2] = 1'b1;
            if (dest_err_q || pay_err_q || !pay_ok || !len_ok) err_inc = 2'd1;
            else begin
               pkt_count_d = pkt_count_q + 8'd1;
               last_src_d  = src_q;
            end
         end
      end
      err_sum     = {1'b0, err_count_q} + {7'd0, err_inc};
      err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
   end
   // State and counter registers
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state_q      <= IDLE;
         k_q          <= '0;
         len_q        <= '0;
         seq_q        <= '0;
         src_q        <= '0;
         dest_err_q   <= 1'b0;
         pay_err_q    <= 1'b0;
         pkt_count_q  <= '0;
         flit_count_q <= '0;
         err_count_q  <= '0;
         err_flags_q  <= '0;
         last_src_q   <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         len_q        <= len_d;
         seq_q        <= seq_d;
         src_q        <= src_d;
         dest_err_q   <= dest_err_d;
         pay_err_q    <= pay_err_d;
         pkt_count_q  <= pkt_count_d;
         flit_count_q <= flit_count_d;
         err_count_q  <= err_count_d;
         err_flags_q  <= err_flags_d;
         last_src_q   <= last_src_d;
      end
   end
   assign pkt_count  = pkt_count_q;
   assign flit_count = flit_count_q;
   assign err_count  = err_count_q;
   assign err_flags  = err_flags_q;
   assign last_src   = last_src_q;
   assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_noc_packet_sink_checker.sv
// tb_noc_packet_sink_checker: directed and randomized packet traffic against a packet-level expectation model
module tb_noc_packet_sink_checker;
   logic        noc_clk = 1'b0;
   logic        noc_rst_n = 1'b1;
   logic [7:0]  pkt_count, err_count, last_src;
   logic [15:0] flit_count;
   logic [4:0]  err_flags;
   logic        busy;
   int          checks = 0, errors = 0;
   logic [7:0]  exp_pkt, exp_err, exp_last;
   logic [15:0] exp_flits;
   logic [4:0]  exp_flags;
   logic        seen_rdy0 = 1'b0, seen_rdy1 = 1'b0;
`ifdef NOC_SINK_BACKPRESSURE_EN
   localparam logic RST_RDY = 1'b0;
`else
   localparam logic RST_RDY = 1'b1;
`endif

   noc_packet_sink_checker_if #(.DATA_W(32)) rx ();

   noc_packet_sink_checker #(.DATA_W(32), .X_ID(1), .Y_ID(1), .CHECK_PAYLOAD(1)) dut (
      .noc_clk    (noc_clk),
      .noc_rst_n  (noc_rst_n),
      .rx         (rx),
      .pkt_count  (pkt_count),
      .flit_count (flit_count),
      .err_count  (err_count),
      .err_flags  (err_flags),
      .last_src   (last_src),
      .busy       (busy)
   );

   always #5 noc_clk = ~noc_clk;

   always @(negedge noc_clk) if (noc_rst_n) begin
      if (rx.receive_ready) seen_rdy1 = 1'b1;
      else seen_rdy0 = 1'b1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] hdr(input logic [7:0] seq, len, input logic [3:0] sx, sy, dx, dy);
      return {seq, len, sx, sy, dx, dy};
   endfunction

   function automatic logic [31:0] body(input logic [7:0] seq, k);
      return {16'($urandom), seq, k};
   endfunction

   task automatic idle_inputs();
      rx.receive_valid = 1'b0;
      rx.receive_is_header = 1'b0;
      rx.receive_is_tail = 1'b0;
      rx.receive_flit = '0;
   endtask

   task automatic model_clear();
      exp_pkt = 0; exp_err = 0; exp_last = 0; exp_flits = 0; exp_flags = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge noc_clk);
      noc_rst_n = 1'b0;
      repeat (2) @(negedge noc_clk);
      noc_rst_n = 1'b1;
      model_clear();
   endtask

   // Present one flit at a negedge and hold it until an edge with ready high takes it
   task automatic send(input logic h, t, input logic [31:0] d);
      int n = 0;
      rx.receive_valid = 1'b1;
      rx.receive_is_header = h;
      rx.receive_is_tail = t;
      rx.receive_flit = d;
      while (!rx.receive_ready && n < 1000) begin
         @(negedge noc_clk);
         n++;
      end
      if (n >= 1000) begin
         checks++; errors++;
         $display("FAIL ready_timeout got ready=0 want ready=1 within 1000 cycles");
      end else begin
         @(negedge noc_clk);
         exp_flits++;
      end
      idle_inputs();
   endtask

   // kind: 0 good, 1 wrong dest, 2 bad payload, 3 too long, 4 too short, 5 missing tail, 6 orphan
   task automatic send_pkt(input int kind);
      logic [7:0] seq = 8'($urandom);
      logic [7:0] len;
      logic [3:0] sx = 4'($urandom), sy = 4'($urandom);
      logic [3:0] dx = 4'd1, dy = 4'd1;
      logic [31:0] d;
      int m, bad;
      if (kind == 6) begin
         send(1'b0, 1'($urandom), 32'($urandom));
         exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
         exp_flags[0] = 1'b1;
         return;
      end
      len = (kind == 4 || kind == 5) ? 8'($urandom_range(2, 6)) : (kind == 2) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(0, 6));
      m = int'(len);
      if (kind == 1) begin dx = 4'($urandom_range(2, 15)); dy = 4'($urandom); end
      if (kind == 3) m = int'(len) + int'($urandom_range(1, 3));
      if (kind == 4) m = int'($urandom_range(1, int'(len) - 1));
      if (kind == 5) m = int'($urandom_range(0, int'(len) - 1));
      bad = (kind == 2) ? int'($urandom_range(1, int'(len))) : -1;
      send(1'b1, (m == 0) && (kind != 5), hdr(seq, len, sx, sy, dx, dy));
      for (int k = 1; k <= m; k++) begin
         d = body(seq, 8'(k));
         if (k == bad) d[0] = ~d[0];
         send(1'b0, (k == m) && (kind != 5), d);
      end
      if (kind == 0) begin
         exp_pkt++;
         exp_last = {sx, sy};
      end else begin
         exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
         exp_flags = exp_flags | ((kind == 1) ? 5'b00100 : (kind == 2) ? 5'b10000 : (kind == 5) ? 5'b00010 : 5'b01000);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      @(negedge noc_clk);
      noc_rst_n = 1'b0;
      #1;
      checks++; if ({pkt_count, flit_count, err_count, err_flags, last_src, busy} !== 46'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", {pkt_count, flit_count, err_count, err_flags, last_src, busy}); end
      checks++; if (rx.receive_ready !== RST_RDY) begin errors++; $display("FAIL reset_ready got %b want %b", rx.receive_ready, RST_RDY); end
      repeat (2) @(negedge noc_clk);
      noc_rst_n = 1'b1;
      model_clear();
      #1;
      checks++; if (rx.receive_ready !== RST_RDY) begin errors++; $display("FAIL release_ready got %b want %b", rx.receive_ready, RST_RDY); end
   endtask

   task automatic test_basic();
      do_reset();
      send(1, 0, 32'h05_03_0011); send(0, 0, 32'h0501); send(0, 0, 32'h0502); send(0, 1, 32'h0503);
      checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL basic_pkt got %0d want 1", pkt_count); end
      checks++; if (last_src !== 8'h00) begin errors++; $display("FAIL basic_src got %h want 00", last_src); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL basic_err got %0d want 0", err_count); end
      checks++; if (flit_count !== 16'd4) begin errors++; $display("FAIL basic_flits got %0d want 4", flit_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
   endtask

   task automatic test_dest();
      do_reset();
      send(1, 0, 32'h05_03_0000); send(0, 0, 32'h0501); send(0, 0, 32'h0502); send(0, 1, 32'h0503);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL dest_err got %0d want 1", err_count); end
      checks++; if (err_flags !== 5'b00100) begin errors++; $display("FAIL dest_flags got %b want 00100", err_flags); end
      checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL dest_pkt got %0d want 0", pkt_count); end
   endtask

   task automatic test_orphan();
      do_reset();
      send(0, 0, 32'h0501);
      checks++; if (err_flags !== 5'b00001) begin errors++; $display("FAIL orphan_flags got %b want 00001", err_flags); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL orphan_err got %0d want 1", err_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL orphan_busy got %b want 0", busy); end
   endtask

   task automatic test_missing_tail();
      do_reset();
      send(1, 0, 32'h07_02_0011); send(0, 0, 32'h0701);
      send(1, 0, 32'h08_01_0011); send(0, 1, 32'h0801);
      checks++; if (err_flags !== 5'b00010) begin errors++; $display("FAIL mtail_flags got %b want 00010", err_flags); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mtail_err got %0d want 1", err_count); end
      checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL mtail_pkt got %0d want 1", pkt_count); end
   endtask

   task automatic test_drain();
      do_reset();
      send(1, 0, 32'h09_01_0011); send(0, 0, 32'h0901);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy1 got %b want 1", busy); end
      send(0, 0, 32'h0902);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy2 got %b want 1", busy); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL drain_err_early got %0d want 0", err_count); end
      send(0, 1, 32'h0903);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy3 got %b want 0", busy); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL drain_err got %0d want 1", err_count); end
      checks++; if (err_flags !== 5'b01000) begin errors++; $display("FAIL drain_flags got %b want 01000", err_flags); end
      send(1, 1, 32'h0A_00_0011);
      checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL single_pkt got %0d want 1", pkt_count); end
   endtask

   task automatic test_len255();
      do_reset();
      send(1, 0, hdr(8'h3C, 8'hFF, 4'h2, 4'h7, 4'h1, 4'h1));
      for (int k = 1; k < 255; k++) send(0, 0, body(8'h3C, 8'(k)));
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len255_busy got %b want 1", busy); end
      send(0, 1, body(8'h3C, 8'hFF));
      checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL len255_pkt got %0d want 1", pkt_count); end
      checks++; if (last_src !== 8'h27) begin errors++; $display("FAIL len255_src got %h want 27", last_src); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL len255_err got %0d want 0", err_count); end
      checks++; if (flit_count !== 16'd256) begin errors++; $display("FAIL len255_flits got %0d want 256", flit_count); end
   endtask

   task automatic test_wrap_saturate();
      do_reset();
      for (int i = 0; i < 257; i++) send(1, 1, hdr(8'(i), 8'd0, 4'h3, 4'h4, 4'h1, 4'h1));
      checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL pkt_wrap got %0d want 1", pkt_count); end
      for (int i = 0; i < 260; i++) send(0, 0, 32'($urandom));
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_sat got %0d want 255", err_count); end
      checks++; if (flit_count !== 16'd517) begin errors++; $display("FAIL wrap_flits got %0d want 517", flit_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(1, 1, 32'h01_00_5611);
      send(1, 0, 32'h05_03_0011); send(0, 0, 32'h0501);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
      @(posedge noc_clk);
      #2 noc_rst_n = 1'b0;
      #1;
      checks++; if ({pkt_count, flit_count, err_count, err_flags, last_src, busy} !== 46'd0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", {pkt_count, flit_count, err_count, err_flags, last_src, busy}); end
      checks++; if (rx.receive_ready !== RST_RDY) begin errors++; $display("FAIL mid_reset_ready got %b want %b", rx.receive_ready, RST_RDY); end
      @(negedge noc_clk);
      noc_rst_n = 1'b1;
      model_clear();
      send(0, 0, 32'h0502);
      checks++; if (err_flags !== 5'b00001) begin errors++; $display("FAIL mid_orphan_flags got %b want 00001", err_flags); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mid_orphan_err got %0d want 1", err_count); end
   endtask

   task automatic test_valid_stream();
      do_reset();
      for (int i = 0; i < 100; i++) send_pkt(0);
      checks++; if (pkt_count !== 8'd100) begin errors++; $display("FAIL stream_pkt got %0d want 100", pkt_count); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL stream_err got %0d want 0", err_count); end
      checks++; if (flit_count !== exp_flits) begin errors++; $display("FAIL stream_flits got %0d want %0d", flit_count, exp_flits); end
      checks++; if (last_src !== exp_last) begin errors++; $display("FAIL stream_src got %h want %h", last_src, exp_last); end
`ifdef NOC_SINK_BACKPRESSURE_EN
      checks++; if ({seen_rdy0, seen_rdy1} !== 2'b11) begin errors++; $display("FAIL ready_both got %b want 11", {seen_rdy0, seen_rdy1}); end
`endif
   endtask

   task automatic test_random();
      int kind;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 6));
         send_pkt(kind);
         if (kind == 5) send_pkt(0);
         checks++; if (pkt_count !== exp_pkt) begin errors++; $display("FAIL rnd_pkt #%0d kind %0d got %0d want %0d", i, kind, pkt_count, exp_pkt); end
         checks++; if (err_count !== exp_err) begin errors++; $display("FAIL rnd_err #%0d kind %0d got %0d want %0d", i, kind, err_count, exp_err); end
         checks++; if (err_flags !== exp_flags) begin errors++; $display("FAIL rnd_flags #%0d kind %0d got %b want %b", i, kind, err_flags, exp_flags); end
         checks++; if (flit_count !== exp_flits) begin errors++; $display("FAIL rnd_flits #%0d kind %0d got %0d want %0d", i, kind, flit_count, exp_flits); end
         checks++; if (last_src !== exp_last) begin errors++; $display("FAIL rnd_src #%0d kind %0d got %h want %h", i, kind, last_src, exp_last); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy #%0d kind %0d got %b want 0", i, kind, busy); end
      end
   endtask

   initial begin
      idle_inputs();
      model_clear();
      test_reset();
      test_basic();
      test_dest();
      test_orphan();
      test_missing_tail();
      test_drain();
      test_len255();
      test_wrap_saturate();
      test_reset_mid();
      test_valid_stream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
